// File: rtl/sm83_dbg_pkg.sv
// Shared types and command-byte constants for the SM83 debug link host.
package sm83_dbg_pkg;

    typedef enum logic [3:0] {
        OP_HALT    = 4'd0,
        OP_CONT    = 4'd1,
        OP_STEP    = 4'd2,
        OP_NOP     = 4'd3,
        OP_SNAP    = 4'd4,
        OP_SET_BP  = 4'd5,
        OP_SET_DRV = 4'd6,
        OP_NOINC   = 4'd7,
        OP_ENABLE  = 4'd8,
        OP_DISABLE = 4'd9
    } op_t;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_REJECTED = 2'd1,
        ST_TIMEOUT  = 2'd2,
        ST_BADOP    = 2'd3
    } status_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_STALE
    } host_state_t;

    localparam logic [7:0] CMD_HALT   = 8'h00;
    localparam logic [7:0] CMD_NOP    = 8'h01;
    localparam logic [7:0] CMD_STEP   = 8'h02;
    localparam logic [7:0] CMD_CONT   = 8'h03;
    localparam logic [7:0] CMD_PREP   = 8'h10;
    localparam logic [7:0] CMD_CTRL   = 8'h20;
    localparam logic [7:0] CMD_SETDRV = 8'h40;
    localparam logic [7:0] CMD_BP     = 8'h80;

    localparam logic [7:0] UNLOCK_MAGIC = 8'h8A;

    function automatic logic [4:0] op_len(input logic [3:0] op, input logic [4:0] snap_len);
        case (op)
            OP_SNAP:                         op_len = snap_len;
            OP_SET_BP:                       op_len = 5'd4;
            OP_SET_DRV, OP_ENABLE, OP_DISABLE: op_len = 5'd3;
            default:                         op_len = 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/sm83_dbg_host_xfer.sv
// Single-byte engine: presents one command byte on the toggle handshake,
// takes responses, and classifies the outcome as responded, rejected or timed out.
module sm83_dbg_host_xfer #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue,
    input  logic       wait_en,
    input  logic       drain,
    input  logic [7:0] tx_byte,
    output logic [7:0] link_tx,
    output logic       link_tx_valid,
    output logic       link_tx_seq,
    input  logic       link_tx_ack,
    input  logic       link_rx_seq,
    output logic       link_rx_ack,
    output logic       rx_take,
    output logic       ev_ok,
    output logic       ev_rej,
    output logic       ev_tmo,
    output logic       tx_idle
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tmo_cnt;
    logic          responded;
    logic          rx_pend;

    assign rx_pend = (link_rx_seq != link_rx_ack);
    assign tx_idle = (link_tx_ack == link_tx_seq);
    assign rx_take = wait_en & rx_pend;
    // Response outranks ack, so a same-cycle ack is only seen one cycle later.
    assign ev_ok   = wait_en & ~rx_pend & tx_idle & responded;
    assign ev_rej  = wait_en & ~rx_pend & tx_idle & ~responded;
    assign ev_tmo  = wait_en & ~rx_pend & ~tx_idle & (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            link_tx       <= '0;
            link_tx_valid <= 1'b0;
            link_tx_seq   <= link_tx_ack;
            link_rx_ack   <= link_rx_seq;
            tmo_cnt       <= '0;
            responded     <= 1'b0;
        end else begin
            if (issue) begin
                link_tx       <= tx_byte;
                link_tx_valid <= 1'b1;
                link_tx_seq   <= ~link_tx_seq;
                tmo_cnt       <= '0;
                responded     <= 1'b0;
            end
            if (wait_en) begin
                tmo_cnt <= tmo_cnt + CW'(1);
                if (rx_pend) begin
                    link_rx_ack <= link_rx_seq;
                    responded   <= 1'b1;
                end else if (tx_idle) begin
                    link_tx_valid <= 1'b0;
                end
            end
            if (drain) begin
                if (rx_pend) link_rx_ack <= link_rx_seq;
                if (tx_idle) link_tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sm83_dbg_host.sv
// Debug-request sequencer: expands each op into its command-byte sequence,
// runs the bytes through the xfer engine, and keeps the snapshot store.
module sm83_dbg_host
    import sm83_dbg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned SNAP_LEN       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [1:0]  req_idx,
    input  logic [15:0] req_arg,
    output logic        done,
    output logic [1:0]  status,
    output logic [7:0]  last_resp,
    output logic [63:0] snap,
    output logic        snap_valid,
    output logic [7:0]  link_tx,
    output logic        link_tx_valid,
    output logic        link_tx_seq,
    input  logic        link_tx_ack,
    input  logic [7:0]  link_rx,
    input  logic        link_rx_seq,
    output logic        link_rx_ack
);
    host_state_t state;
    logic [3:0]  op_q;
    logic [1:0]  idx_q;
    logic [15:0] arg_q;
    logic [4:0]  step;
    logic [7:0]  cmd;
    logic        rx_take, ev_ok, ev_rej, ev_tmo, tx_idle;

    function automatic logic [7:0] cmd_byte(input logic [3:0] op, input logic [1:0] idx,
                                            input logic [15:0] arg, input logic [4:0] stp);
        logic [3:0] nib;
        nib = arg[{stp[1:0], 2'b00} +: 4];
        case (op)
            OP_HALT:         cmd_byte = CMD_HALT;
            OP_CONT:         cmd_byte = CMD_CONT;
            OP_STEP:         cmd_byte = CMD_STEP;
            OP_NOP, OP_SNAP: cmd_byte = CMD_NOP;
            OP_SET_BP:       cmd_byte = CMD_BP | {2'b00, idx, nib};
            OP_SET_DRV:      cmd_byte = (stp == 5'd0) ? (CMD_PREP | {4'h0, arg[3:0]}) :
                                        (stp == 5'd1) ? (CMD_PREP | {4'h0, arg[7:4]}) :
                                        (CMD_SETDRV | {2'b00, arg[8], 3'b000, idx});
            OP_NOINC:        cmd_byte = CMD_CTRL | {6'b0, arg[0], 1'b0};
            OP_ENABLE, OP_DISABLE:
                cmd_byte = (stp == 5'd0) ? (CMD_PREP | {4'h0, UNLOCK_MAGIC[3:0]}) :
                           (stp == 5'd1) ? (CMD_PREP | {4'h0, UNLOCK_MAGIC[7:4]}) :
                           (op == OP_ENABLE) ? (CMD_SETDRV | 8'h01) : (CMD_CTRL | 8'h01);
            default:         cmd_byte = '0;
        endcase
    endfunction

    assign req_ready = (state == S_IDLE);

    sm83_dbg_host_xfer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_xfer (
        .clk           (clk),
        .reset         (reset),
        .issue         (state == S_ISSUE),
        .wait_en       (state == S_WAIT),
        .drain         (state == S_STALE),
        .tx_byte       (cmd),
        .link_tx       (link_tx),
        .link_tx_valid (link_tx_valid),
        .link_tx_seq   (link_tx_seq),
        .link_tx_ack   (link_tx_ack),
        .link_rx_seq   (link_rx_seq),
        .link_rx_ack   (link_rx_ack),
        .rx_take       (rx_take),
        .ev_ok         (ev_ok),
        .ev_rej        (ev_rej),
        .ev_tmo        (ev_tmo),
        .tx_idle       (tx_idle)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            op_q       <= '0;
            idx_q      <= '0;
            arg_q      <= '0;
            step       <= '0;
            cmd        <= '0;
            done       <= 1'b0;
            status     <= ST_OK;
            last_resp  <= '0;
            snap       <= '0;
            snap_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: if (req_valid) begin
                    op_q  <= req_op;
                    idx_q <= req_idx;
                    arg_q <= req_arg;
                    step  <= '0;
                    if (req_op == OP_SNAP) snap_valid <= 1'b0;
                    state <= S_LOAD;
                end
                S_LOAD: if (op_q > OP_DISABLE) begin
                    done   <= 1'b1;
                    status <= ST_BADOP;
                    state  <= S_IDLE;
                end else begin
                    cmd   <= cmd_byte(op_q, idx_q, arg_q, step);
                    state <= S_ISSUE;
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: if (rx_take) begin
                    last_resp <= link_rx;
                    if (op_q == OP_SNAP) snap[{link_rx[7:4], 2'b00} +: 4] <= link_rx[3:0];
                end else if (ev_ok) begin
                    if (step + 5'd1 == op_len(op_q, 5'(SNAP_LEN))) begin
                        done   <= 1'b1;
                        status <= ST_OK;
                        if (op_q == OP_SNAP) snap_valid <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        step  <= step + 5'd1;
                        state <= S_LOAD;
                    end
                end else if (ev_rej) begin
                    done   <= 1'b1;
                    status <= ST_REJECTED;
                    state  <= S_IDLE;
                end else if (ev_tmo) begin
                    done   <= 1'b1;
                    status <= ST_TIMEOUT;
                    state  <= S_STALE;
                end
                S_STALE: if (tx_idle) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm83_dbg_host.sv
// Directed bench for sm83_dbg_host with an inline target model driven at negedges.
module tb_sm83_dbg_host;
    import sm83_dbg_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0;
    logic [1:0]  req_idx = '0;
    logic [15:0] req_arg = '0;
    logic        done;
    logic [1:0]  status;
    logic [7:0]  last_resp;
    logic [63:0] snap;
    logic        snap_valid;
    logic [7:0]  link_tx;
    logic        link_tx_valid;
    logic        link_tx_seq;
    logic        link_tx_ack = 1'b1;
    logic [7:0]  link_rx = '0;
    logic        link_rx_seq = 1'b0;
    logic        link_rx_ack;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sm83_dbg_host #(.TIMEOUT_CYCLES(4096), .SNAP_LEN(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_idx(req_idx), .req_arg(req_arg),
        .done(done), .status(status), .last_resp(last_resp),
        .snap(snap), .snap_valid(snap_valid),
        .link_tx(link_tx), .link_tx_valid(link_tx_valid),
        .link_tx_seq(link_tx_seq), .link_tx_ack(link_tx_ack),
        .link_rx(link_rx), .link_rx_seq(link_rx_seq), .link_rx_ack(link_rx_ack)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [3:0] op, input logic [1:0] idx, input logic [15:0] arg);
        for (int i = 0; i < 16 && req_ready !== 1'b1; i++) @(negedge clk);
        check("req_ready_before_req", req_ready, 1'b1);
        req_valid = 1'b1; req_op = op; req_idx = idx; req_arg = arg;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Target model for one command byte: optional response, optional ack.
    task automatic serve_byte(input logic do_resp, input logic [7:0] resp,
                              input logic do_ack, output logic [7:0] got);
        for (int i = 0; i < 64 && link_tx_seq === link_tx_ack; i++) @(negedge clk);
        check("byte_presented", link_tx_seq !== link_tx_ack, 1'b1);
        check("tx_valid", link_tx_valid, 1'b1);
        got = link_tx;
        if (do_resp) begin
            link_rx = resp;
            link_rx_seq = ~link_rx_seq;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                if (link_rx_ack === link_rx_seq) break;
            end
            check("rx_acked", link_rx_ack === link_rx_seq, 1'b1);
        end
        if (do_ack) link_tx_ack = link_tx_seq;
    endtask

    task automatic wait_done(input string tag, input logic [1:0] exp_st, input int limit);
        logic got;
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin got = 1'b1; break; end
        end
        check({tag, "_done"}, got, 1'b1);
        if (got) check({tag, "_status"}, status, exp_st);
    endtask

    initial begin : main
        logic [7:0] b;
        logic       saw_done;
        int         cyc;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_status", status, 2'd0);
        check("rst_last_resp", last_resp, 8'h00);
        check("rst_snap", snap, 64'h0);
        check("rst_snap_valid", snap_valid, 1'b0);
        check("rst_tx", link_tx, 8'h00);
        check("rst_tx_valid", link_tx_valid, 1'b0);
        check("rst_tx_seq", link_tx_seq, 1'b1);
        check("rst_rx_ack", link_rx_ack, 1'b0);

        // HALT: respond 0x31 then ack
        send_req(OP_HALT, 2'd0, 16'h0);
        serve_byte(1'b1, 8'h31, 1'b1, b);
        check("halt_byte", b, 8'h00);
        wait_done("halt", ST_OK, 16);
        check("halt_last_resp", last_resp, 8'h31);
        check("halt_single_byte", link_tx_seq === link_tx_ack, 1'b1);

        // SET_BP while target running: ack without response
        send_req(OP_SET_BP, 2'd1, 16'h1234);
        serve_byte(1'b0, 8'h00, 1'b1, b);
        check("bp_rej_byte", b, 8'h94);
        wait_done("bp_rej", ST_REJECTED, 16);
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("bp_rej_no_more_bytes", link_tx_seq === link_tx_ack, 1'b1);
        check("bp_rej_last_resp", last_resp, 8'h31);

        // SET_BP while halted
        send_req(OP_SET_BP, 2'd0, 16'h1234);
        serve_byte(1'b1, 8'h20, 1'b1, b); check("bp_b0", b, 8'h84);
        serve_byte(1'b1, 8'h20, 1'b1, b); check("bp_b1", b, 8'h83);
        serve_byte(1'b1, 8'h20, 1'b1, b); check("bp_b2", b, 8'h82);
        serve_byte(1'b1, 8'h20, 1'b1, b); check("bp_b3", b, 8'h81);
        wait_done("bp_ok", ST_OK, 16);

        // SET_DRV idx 2, byte 0xA5, drive flag set
        send_req(OP_SET_DRV, 2'd2, 16'h01A5);
        serve_byte(1'b1, 8'h00, 1'b1, b); check("drv_b0", b, 8'h15);
        serve_byte(1'b1, 8'h00, 1'b1, b); check("drv_b1", b, 8'h1A);
        serve_byte(1'b1, 8'h00, 1'b1, b); check("drv_b2", b, 8'h62);
        wait_done("drv", ST_OK, 16);

        // NOINC set
        send_req(OP_NOINC, 2'd0, 16'h0001);
        serve_byte(1'b1, 8'h55, 1'b1, b); check("noinc_byte", b, 8'h22);
        wait_done("noinc", ST_OK, 16);
        check("noinc_last_resp", last_resp, 8'h55);

        // SNAP: response k carries nibble 15-k at index k
        send_req(OP_SNAP, 2'd0, 16'h0);
        check("snap_valid_cleared", snap_valid, 1'b0);
        for (int k = 0; k < 16; k++) begin
            serve_byte(1'b1, 8'((k << 4) | (15 - k)), 1'b1, b);
            check("snap_byte", b, 8'h01);
        end
        wait_done("snap", ST_OK, 16);
        check("snap_value", snap, 64'h0123456789ABCDEF);
        check("snap_valid_set", snap_valid, 1'b1);
        check("snap_last_resp", last_resp, 8'hF0);

        // Undefined op
        send_req(4'd12, 2'd0, 16'h0);
        wait_done("badop", ST_BADOP, 8);
        check("badop_no_byte", link_tx_seq === link_tx_ack, 1'b1);

        // STEP never acked
        send_req(OP_STEP, 2'd0, 16'h0);
        serve_byte(1'b0, 8'h00, 1'b0, b);
        check("step_byte", b, 8'h02);
        cyc = 0;
        saw_done = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin saw_done = 1'b1; break; end
        end
        check("tmo_done", saw_done, 1'b1);
        check("tmo_status", status, ST_TIMEOUT);
        check("tmo_cycles", cyc, 4096);
        @(negedge clk);
        check("stale_not_ready", req_ready, 1'b0);
        link_rx = 8'h77;
        link_rx_seq = ~link_rx_seq;
        @(negedge clk); @(negedge clk);
        check("stale_rx_acked", link_rx_ack === link_rx_seq, 1'b1);
        check("stale_last_resp", last_resp, 8'hF0);
        check("stale_still_not_ready", req_ready, 1'b0);
        link_tx_ack = link_tx_seq;
        @(negedge clk);
        check("stale_exit_ready", req_ready, 1'b1);

        // ENABLE aborted by reset on its third byte
        send_req(OP_ENABLE, 2'd0, 16'h0);
        serve_byte(1'b1, 8'h00, 1'b1, b); check("en_b0", b, 8'h1A);
        serve_byte(1'b1, 8'h00, 1'b1, b); check("en_b1", b, 8'h18);
        serve_byte(1'b0, 8'h00, 1'b0, b); check("en_b2", b, 8'h41);
        reset = 1'b1;
        saw_done = 1'b0;
        repeat (3) begin @(negedge clk); saw_done |= done; end
        reset = 1'b0;
        @(negedge clk);
        saw_done |= done;
        check("rst_mid_seq_idle", link_tx_seq === link_tx_ack, 1'b1);
        check("rst_mid_ready", req_ready, 1'b1);
        repeat (4) begin @(negedge clk); saw_done |= done; end
        check("rst_mid_no_done", saw_done, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
